// File: rtl/fifo_read_arbiter.sv
// Shares one egress datapath between NUM_PORTS FIFO read sides. Grants are
// packet-level round-robin; words leave through a registered ready/valid stage.
module fifo_read_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int PORT_W     = $clog2(NUM_PORTS)
) (
  input  logic                                rclk,
  input  logic                                reset,
  input  logic                                arb_enable,
  input  logic [NUM_PORTS-1:0]                fifo_empty,
  input  logic [NUM_PORTS*(DATA_WIDTH+1)-1:0] fifo_rdata,
  output logic [NUM_PORTS-1:0]                fifo_rd_en,
  output logic [DATA_WIDTH-1:0]               out_data,
  output logic                                out_last,
  output logic [PORT_W-1:0]                   out_port,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                busy,
  output logic [15:0]                         pkt_count
);
  localparam int WORD_W = DATA_WIDTH + 1;

  typedef enum logic {IDLE, XFER} state_t;

  state_t            state, state_nxt;
  logic [PORT_W-1:0] grant, grant_nxt, last_grant, last_grant_nxt, pick;
  logic              found, load, pop_eop;
  logic [WORD_W-1:0] words [NUM_PORTS];
  logic [WORD_W-1:0] head;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_slice
    assign words[i] = fifo_rdata[i*WORD_W +: WORD_W];
  end

  assign head    = words[grant];
  assign busy    = (state == XFER);
  assign load    = (state == XFER) && !fifo_empty[grant] && (!out_valid || out_ready);
  assign pop_eop = load && head[DATA_WIDTH];

  // Gated by reset so no pop can escape while registered state is still stale.
  assign fifo_rd_en = (load && !reset) ? (NUM_PORTS'(1) << grant) : '0;

  // Round-robin search starting just after the last port that finished a packet.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int off = 1; off <= NUM_PORTS; off++) begin
      if (!found && !fifo_empty[(int'(last_grant) + off) % NUM_PORTS]) begin
        found = 1'b1;
        pick  = PORT_W'((int'(last_grant) + off) % NUM_PORTS);
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        if (arb_enable && found) begin
          state_nxt = XFER;
          grant_nxt = pick;
        end
      end
      XFER: begin
        if (pop_eop) begin
          state_nxt      = IDLE;
          last_grant_nxt = grant;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= PORT_W'(NUM_PORTS - 1);
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      out_port   <= '0;
      pkt_count  <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= head[DATA_WIDTH-1:0];
        out_last  <= head[DATA_WIDTH];
        out_port  <= grant;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (pop_eop) pkt_count <= pkt_count + 16'd1;
    end
  end

  a_rd_onehot: assert property (@(posedge rclk) disable iff (reset) $onehot0(fifo_rd_en));
  a_rd_nonempty: assert property (@(posedge rclk) disable iff (reset) (fifo_rd_en & fifo_empty) == '0);
  a_out_stable: assert property (@(posedge rclk) disable iff (reset)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_last) && $stable(out_port)));
endmodule
